// File: rtl/input_reader_pkg.sv
// Shared constants for the switch/key input reader: bus widths and the register map.
package input_reader_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned BE_W   = 4;

  localparam logic [ADDR_W-1:0] ADDR_SWITCHES = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_KEYS     = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_EDGE     = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_MASK     = 2'd3;

endpackage

// File: rtl/input_debouncer.sv
// Per-bit two-flop synchroniser followed by a stable-count debouncer.
module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          RESET_VAL       = 1'b0,
  parameter bit          INVERT          = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned   CntW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            db_q, db_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level;

  // Inversion happens after the synchroniser so the sync flops see raw pin levels.
  assign level = sync2_q ^ INVERT;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (level != db_q) begin
      if (cnt_q == CntMax) begin
        db_d = level;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= RESET_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/input_reader.sv
// Avalon-MM slave exposing debounced switches/keys, key-press edge capture and a masked irq.
module input_reader
  import input_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned NUM_SWITCHES    = 10,
  parameter int unsigned NUM_KEYS        = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_W-1:0]       writedata,
  input  logic [BE_W-1:0]         byteenable,
  output logic [DATA_W-1:0]       readdata,
  output logic                    readdatavalid,
  output logic                    irq,
  input  logic [NUM_SWITCHES-1:0] switches,
  input  logic [NUM_KEYS-1:0]     keys_n
);

  logic [NUM_SWITCHES-1:0] sw_db;
  logic [NUM_KEYS-1:0]     key_db;
  logic [NUM_KEYS-1:0]     key_prev_q;
  logic [NUM_KEYS-1:0]     key_rise;
  logic [NUM_KEYS-1:0]     edge_q, edge_d;
  logic [NUM_KEYS-1:0]     mask_q, mask_d;
  logic [NUM_KEYS-1:0]     w1c;
  logic                    irq_q, irq_d;
  logic [DATA_W-1:0]       readdata_q, readdata_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_W-1:0]       rd_mux;
  logic                    wr_low;
  logic                    unused_bus;

  assign unused_bus = ^{writedata[DATA_W-1:NUM_KEYS], byteenable[BE_W-1:1]};

  for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_sw
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b0),
      .INVERT         (1'b0)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (switches[i]),
      .dout   (sw_db[i])
    );
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b0),
      .INVERT         (1'b1)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (keys_n[i]),
      .dout   (key_db[i])
    );
  end

  assign wr_low = write & byteenable[0];

  always_comb begin
    key_rise = key_db & ~key_prev_q;
    w1c      = '0;
    mask_d   = mask_q;
    if (wr_low && (address == ADDR_EDGE)) w1c    = writedata[NUM_KEYS-1:0];
    if (wr_low && (address == ADDR_MASK)) mask_d = writedata[NUM_KEYS-1:0];
    // A fresh press beats a simultaneous clear of the same bit.
    edge_d = (edge_q & ~w1c) | key_rise;
    irq_d  = |(edge_q & mask_q);
  end

  // Read mux uses pre-write register values so a same-cycle write is not visible.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_SWITCHES: rd_mux[NUM_SWITCHES-1:0] = sw_db;
      ADDR_KEYS:     rd_mux[NUM_KEYS-1:0]     = key_db;
      ADDR_EDGE:     rd_mux[NUM_KEYS-1:0]     = edge_q;
      ADDR_MASK:     rd_mux[NUM_KEYS-1:0]     = mask_q;
      default:       rd_mux                   = '0;
    endcase
    readdata_d = read ? rd_mux : readdata_q;
    rvalid_d   = read;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_prev_q <= '0;
      edge_q     <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      key_prev_q <= key_db;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rvalid_q;
  assign irq           = irq_q;

endmodule
